// File: rtl/moravec_pkg.sv
// Shared types and constants for the Moravec window scoring datapath.
// Direction tables are indexed by DIR_E/DIR_S/DIR_SE/DIR_SW.
package moravec_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SCORE = 3'd2,
        MIN   = 3'd3,
        DONE  = 3'd4
    } mv_state_t;

    localparam int DIR_E  = 0;
    localparam int DIR_S  = 1;
    localparam int DIR_SE = 2;
    localparam int DIR_SW = 3;

    localparam int DIR_DX [4] = '{1, 0, 1, -1};
    localparam int DIR_DY [4] = '{0, 1, 1, 1};

endpackage

// File: rtl/moravec_window_score_sq_diff.sv
// Combinational squared absolute difference of two unsigned pixels.
module sq_diff #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0]   a,
    input  logic [PIX_W-1:0]   b,
    output logic [2*PIX_W-1:0] sq
);

    logic [PIX_W-1:0] diff;

    always_comb begin
        diff = (a > b) ? (a - b) : (b - a);
        sq   = {{PIX_W{1'b0}}, diff} * {{PIX_W{1'b0}}, diff};
    end

endmodule

// File: rtl/moravec_window_score.sv
// Captures an N x N pixel window and computes its Moravec interest score
// (minimum over four directions of summed squared differences of interior pixels).
module moravec_window_score
    import moravec_pkg::*;
#(
    parameter int N       = 8,
    parameter int bitSize = 6,
    parameter int PIX_W   = 8,
    parameter int SCORE_W = 22
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic [bitSize:0]   count_in,
    input  logic               pix_valid,
    output logic               inc_out,
    output logic [SCORE_W-1:0] score_out,
    output logic               score_valid,
    input  logic               score_ready
);

    localparam int CW    = bitSize + 1;
    localparam int IDX_W = $clog2(N * N);

    localparam logic [CW-1:0] LAST_IDX = CW'(N * N - 1);
    localparam logic [CW-1:0] XY_FIRST = CW'(1);
    localparam logic [CW-1:0] XY_LAST  = CW'(N - 2);

    mv_state_t state, next_state;

    logic [PIX_W-1:0]   window [N*N];
    logic [CW-1:0]      x_cnt, y_cnt;
    logic [SCORE_W-1:0] acc [4];

    logic [IDX_W-1:0]   center_idx;
    logic [IDX_W-1:0]   nbr_idx [4];
    logic [2*PIX_W-1:0] sq [4];
    logic [SCORE_W-1:0] min_a, min_b, min_all;

    logic capture;
    logic last_interior;

    assign capture       = (state == FILL) && pix_valid && (count_in == LAST_IDX);
    assign last_interior = (state == SCORE) && (x_cnt == XY_LAST) && (y_cnt == XY_LAST);
    assign inc_out       = (state == FILL);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FILL;
            FILL:    if (capture) next_state = SCORE;
            SCORE:   if (last_interior) next_state = MIN;
            MIN:     next_state = DONE;
            DONE:    if (score_valid && score_ready) next_state = FILL;
            default: next_state = IDLE;
        endcase
    end

    // Window storage is deliberately not reset; unwritten entries keep prior contents.
    always_ff @(posedge clk) begin
        if (!rst && (state == FILL) && pix_valid && (count_in <= LAST_IDX))
            window[count_in[IDX_W-1:0]] <= pix_in;
    end

    always_comb begin
        center_idx = IDX_W'(int'(y_cnt) * N + int'(x_cnt));
        for (int d = 0; d < 4; d++)
            nbr_idx[d] = IDX_W'((int'(y_cnt) + DIR_DY[d]) * N + int'(x_cnt) + DIR_DX[d]);
    end

    for (genvar g = 0; g < 4; g++) begin : g_sq
        sq_diff #(.PIX_W(PIX_W)) u_sq (
            .a  (window[center_idx]),
            .b  (window[nbr_idx[g]]),
            .sq (sq[g])
        );
    end

    always_comb begin
        min_a   = (acc[DIR_E]  < acc[DIR_S])  ? acc[DIR_E]  : acc[DIR_S];
        min_b   = (acc[DIR_SE] < acc[DIR_SW]) ? acc[DIR_SE] : acc[DIR_SW];
        min_all = (min_a < min_b) ? min_a : min_b;
    end

    // Raster scan over interior pixels while accumulating all four directions.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt       <= XY_FIRST;
            y_cnt       <= XY_FIRST;
            score_out   <= '0;
            score_valid <= 1'b0;
            for (int d = 0; d < 4; d++) acc[d] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (capture) begin
                        x_cnt <= XY_FIRST;
                        y_cnt <= XY_FIRST;
                        for (int d = 0; d < 4; d++) acc[d] <= '0;
                    end
                end
                SCORE: begin
                    for (int d = 0; d < 4; d++)
                        acc[d] <= acc[d] + SCORE_W'(sq[d]);
                    if (x_cnt == XY_LAST) begin
                        x_cnt <= XY_FIRST;
                        y_cnt <= y_cnt + 1'b1;
                    end else begin
                        x_cnt <= x_cnt + 1'b1;
                    end
                end
                MIN: begin
                    score_out   <= min_all;
                    score_valid <= 1'b1;
                end
                DONE: begin
                    if (score_valid && score_ready) score_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
